// File: rtl/ndn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ndn_pkg
// Purpose  : Shared constants, FSM state type and prefix-mask helper for the
//            NDN upstream producer (content store responder).
// Contents : PREFIX_W, LEN_W, BYTE_W, state_t, prefix_mask()
// Revision : 1.0 - initial release
// ============================================================================
package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    SEND   = 3'd2,
    NACK   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // MSB-aligned mask covering the top 'len' bits of a prefix. A zero length
  // yields an all-zero mask, so a length-0 entry matches any length-0 key.
  function automatic logic [PREFIX_W-1:0] prefix_mask(input logic [LEN_W-1:0] len);
    logic [PREFIX_W-1:0] ones;
    logic [PREFIX_W-1:0] mask;
    ones = '1;
    if (len == '0) begin
      mask = '0;
    end else begin
      mask = ones << (PREFIX_W - int'(len));
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ndn_content_store.sv
`default_nettype none
// ============================================================================
// Module   : ndn_content_store
// Purpose  : Local content store. Holds per-entry headers (prefix, prefix
//            length, payload length), a payload RAM with a registered read
//            port, and a parallel prefix matcher with lowest-index priority.
// Ports    : clk, rst (async, active-low)
//            cfg_*        - header/payload write port, gated by cfg_en
//            key_prefix/key_len - lookup key (combinational match outputs)
//            hit, hit_*   - match flag and the winning entry's header
//            rd_en/rd_idx/rd_addr -> rd_data (one-cycle registered read)
// Revision : 1.0 - initial release
// ============================================================================
module ndn_content_store
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int MAX_BYTES = 32,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int BA_W     = $clog2(MAX_BYTES),
  localparam int CL_W     = BA_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  // configuration
  input  logic                cfg_en,
  input  logic                cfg_hdr_we,
  input  logic                cfg_byte_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [PREFIX_W-1:0] cfg_prefix,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [CL_W-1:0]     cfg_content_len,
  input  logic [BA_W-1:0]     cfg_byte_addr,
  input  logic [BYTE_W-1:0]   cfg_byte,
  // lookup
  input  logic [PREFIX_W-1:0] key_prefix,
  input  logic [LEN_W-1:0]    key_len,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic [PREFIX_W-1:0] hit_prefix,
  output logic [LEN_W-1:0]    hit_len,
  output logic [CL_W-1:0]     hit_content_len,
  // payload read
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [BA_W-1:0]     rd_addr,
  output logic [BYTE_W-1:0]   rd_data
);

  logic [PREFIX_W-1:0] hdr_prefix [ENTRIES];
  logic [LEN_W-1:0]    hdr_len    [ENTRIES];
  logic [CL_W-1:0]     hdr_clen   [ENTRIES];
  logic [BYTE_W-1:0]   mem        [ENTRIES*MAX_BYTES];
  logic [ENTRIES-1:0]  entry_hit;
  logic [PREFIX_W-1:0] key_mask;

  // Headers are reset so every entry starts invalid (content length 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        hdr_prefix[i] <= '0;
        hdr_len[i]    <= '0;
        hdr_clen[i]   <= '0;
      end
    end else if (cfg_en && cfg_hdr_we) begin
      hdr_prefix[cfg_idx] <= cfg_prefix;
      hdr_len[cfg_idx]    <= cfg_len;
      hdr_clen[cfg_idx]   <= cfg_content_len;
    end
  end

  // Payload RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_en && cfg_byte_we) begin
      mem[{cfg_idx, cfg_byte_addr}] <= cfg_byte;
    end
  end

  // Registered read: the caller presents the address one cycle ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_idx, rd_addr}];
    end
  end

  assign key_mask = prefix_mask(key_len);

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
      assign entry_hit[i] = (hdr_clen[i] != '0) &&
                            (hdr_len[i] == key_len) &&
                            (((hdr_prefix[i] ^ key_prefix) & key_mask) == '0);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the final assignment.
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_hit[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit             = |entry_hit;
  assign hit_prefix      = hdr_prefix[hit_idx];
  assign hit_len         = hdr_len[hit_idx];
  assign hit_content_len = hdr_clen[hit_idx];

endmodule
`default_nettype wire

// File: rtl/ndn_producer.sv
`default_nettype none
// ============================================================================
// Module   : ndn_producer
// Purpose  : Upstream responder on the router's interest-forwarding side.
//            A forwarded interest is looked up in the local content store;
//            a hit streams the stored payload one byte per cycle, a miss
//            produces a one-cycle NACK.
// Ports    : clk, rst (async, active-low)
//            interest_prefix/len/valid - forwarded interest (level valid)
//            data_in_prefix/len, data_ready, in_data - returned content
//            nack - one-cycle miss pulse;  busy - FSM not idle
//            cfg_* - content store configuration (accepted only when idle)
// Revision : 1.0 - initial release
// ============================================================================
module ndn_producer
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int MAX_BYTES = 32,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int BA_W     = $clog2(MAX_BYTES),
  localparam int CL_W     = BA_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  input  logic                interest_valid,
  output logic [PREFIX_W-1:0] data_in_prefix,
  output logic [LEN_W-1:0]    data_in_len,
  output logic                data_ready,
  output logic [BYTE_W-1:0]   in_data,
  output logic                nack,
  output logic                busy,
  input  logic                cfg_hdr_we,
  input  logic                cfg_byte_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [PREFIX_W-1:0] cfg_prefix,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [CL_W-1:0]     cfg_content_len,
  input  logic [BA_W-1:0]     cfg_byte_addr,
  input  logic [BYTE_W-1:0]   cfg_byte
);

  state_t              state;
  state_t              next_state;
  logic                send_d;
  logic                nack_d;

  logic [PREFIX_W-1:0] key_prefix;
  logic [LEN_W-1:0]    key_len;
  logic [IDX_W-1:0]    send_idx;
  logic [CL_W-1:0]     send_len;
  logic [CL_W-1:0]     cnt;
  logic [CL_W-1:0]     cnt_inc;
  logic                last_byte;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [PREFIX_W-1:0] hit_prefix;
  logic [LEN_W-1:0]    hit_len;
  logic [CL_W-1:0]     hit_content_len;

  logic                cfg_en;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_idx;
  logic [BA_W-1:0]     rd_addr;

  assign busy      = (state != IDLE);
  assign cfg_en    = (state == IDLE);
  assign cnt_inc   = cnt + CL_W'(1);
  assign last_byte = (cnt == send_len - CL_W'(1));

  // The RAM read is issued one cycle ahead of presentation: during LOOKUP
  // it fetches byte 0 of the matching entry, during SEND it fetches the byte
  // after the one currently on in_data. The final SEND cycle's fetch (whose
  // address may wrap) is never presented.
  assign rd_en   = (state == LOOKUP) || (state == SEND);
  assign rd_idx  = (state == LOOKUP) ? hit_idx : send_idx;
  assign rd_addr = (state == LOOKUP) ? '0 : cnt_inc[BA_W-1:0];

  ndn_content_store #(
    .ENTRIES   (ENTRIES),
    .MAX_BYTES (MAX_BYTES)
  ) u_store (
    .clk             (clk),
    .rst             (rst),
    .cfg_en          (cfg_en),
    .cfg_hdr_we      (cfg_hdr_we),
    .cfg_byte_we     (cfg_byte_we),
    .cfg_idx         (cfg_idx),
    .cfg_prefix      (cfg_prefix),
    .cfg_len         (cfg_len),
    .cfg_content_len (cfg_content_len),
    .cfg_byte_addr   (cfg_byte_addr),
    .cfg_byte        (cfg_byte),
    .key_prefix      (key_prefix),
    .key_len         (key_len),
    .hit             (hit),
    .hit_idx         (hit_idx),
    .hit_prefix      (hit_prefix),
    .hit_len         (hit_len),
    .hit_content_len (hit_content_len),
    .rd_en           (rd_en),
    .rd_idx          (rd_idx),
    .rd_addr         (rd_addr),
    .rd_data         (in_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    send_d     = 1'b0;
    nack_d     = 1'b0;
    case (state)
      IDLE:    if (interest_valid) next_state = LOOKUP;
      LOOKUP:  next_state = hit ? SEND : NACK;
      SEND:    if (last_byte) next_state = DONE;
      NACK:    next_state = DONE;
      // A held interest parks here until the router drops it, so the same
      // request is never answered twice.
      DONE:    if (!interest_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    send_d = (next_state == SEND);
    nack_d = (next_state == NACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prefix     <= '0;
      key_len        <= '0;
      send_idx       <= '0;
      send_len       <= '0;
      cnt            <= '0;
      data_in_prefix <= '0;
      data_in_len    <= '0;
      data_ready     <= 1'b0;
      nack           <= 1'b0;
    end else begin
      if ((state == IDLE) && interest_valid) begin
        key_prefix <= interest_prefix;
        key_len    <= interest_len;
      end
      if (state == LOOKUP) begin
        cnt <= '0;
        if (hit) begin
          send_idx       <= hit_idx;
          send_len       <= hit_content_len;
          data_in_prefix <= hit_prefix;
          data_in_len    <= hit_len;
        end
      end else if (state == SEND) begin
        cnt <= cnt_inc;
      end
      data_ready <= send_d;
      nack       <= nack_d;
    end
  end

endmodule
`default_nettype wire
